// File: rtl/dbus_cmd_bridge.sv
// rtl/dbus_cmd_bridge.sv - byte-stream command parser issuing single-word dBus reads/writes
// Packets: 0x57 A0..A3 D0..D3 (write) or 0x52 A0..A3 (read), little-endian; replies 0x06/0x15 [+D0..D3].
module dbus_cmd_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_dBus_cmd_valid,
    input  logic        i_dBus_cmd_ready,
    output logic        o_dBus_cmd_payload_wr,
    output logic [31:0] o_dBus_cmd_payload_address,
    output logic [31:0] o_dBus_cmd_payload_data,
    output logic [1:0]  o_dBus_cmd_payload_size,
    input  logic        i_dBus_rsp_ready,
    input  logic        i_dBus_rsp_error,
    input  logic [31:0] i_dBus_rsp_data,
    output logic        o_busy
);

    localparam logic [7:0]  OP_WRITE = 8'h57;
    localparam logic [7:0]  OP_READ  = 8'h52;
    localparam logic [7:0]  ST_ACK   = 8'h06;
    localparam logic [7:0]  ST_NAK   = 8'h15;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_ISSUE,
        S_WAIT_RSP,
        S_SEND_STAT,
        S_SEND_DATA
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_rx_ready;
    logic        r_tx_valid;
    logic        r_cmd_valid;
    logic [7:0]  r_tx_data;
    logic        r_is_wr;
    logic        r_send_data;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rd_data;
    logic [1:0]  r_cnt;
    logic [15:0] r_tmo;

    logic w_rx_fire;
    logic w_tx_fire;
    logic w_cmd_fire;
    logic w_timeout;
    logic w_opcode_ok;

    assign w_rx_fire   = i_rx_valid && r_rx_ready;
    assign w_tx_fire   = r_tx_valid && i_tx_ready;
    assign w_cmd_fire  = r_cmd_valid && i_dBus_cmd_ready;
    assign w_timeout   = (r_tmo == TMO_LAST) && !i_dBus_rsp_ready;
    assign w_opcode_ok = (i_rx_data == OP_WRITE) || (i_rx_data == OP_READ);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_rx_fire) begin
                    w_next_state = w_opcode_ok ? S_GET_ADDR : S_SEND_STAT;
                end
            end
            S_GET_ADDR: begin
                if (w_rx_fire && r_cnt == 2'd3) begin
                    w_next_state = r_is_wr ? S_GET_DATA : S_ISSUE;
                end
            end
            S_GET_DATA: begin
                if (w_rx_fire && r_cnt == 2'd3) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_cmd_fire) begin
                    w_next_state = r_is_wr ? S_SEND_STAT : S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (i_dBus_rsp_ready || w_timeout) begin
                    w_next_state = S_SEND_STAT;
                end
            end
            S_SEND_STAT: begin
                if (w_tx_fire) begin
                    w_next_state = r_send_data ? S_SEND_DATA : S_IDLE;
                end
            end
            S_SEND_DATA: begin
                if (w_tx_fire && r_cnt == 2'd3) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are glitch-free and
    // low throughout reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_tx_data   <= 8'h00;
            r_is_wr     <= 1'b0;
            r_send_data <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rd_data   <= 32'h0;
            r_cnt       <= 2'd0;
            r_tmo       <= 16'd0;
        end else begin
            r_state     <= w_next_state;
            r_rx_ready  <= (w_next_state == S_IDLE) || (w_next_state == S_GET_ADDR) ||
                           (w_next_state == S_GET_DATA);
            r_tx_valid  <= (w_next_state == S_SEND_STAT) || (w_next_state == S_SEND_DATA);
            r_cmd_valid <= (w_next_state == S_ISSUE);
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        r_is_wr     <= (i_rx_data == OP_WRITE);
                        r_send_data <= 1'b0;
                        r_cnt       <= 2'd0;
                        if (!w_opcode_ok) begin
                            r_tx_data <= ST_NAK;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (w_rx_fire) begin
                        r_addr <= {i_rx_data, r_addr[31:8]};
                        r_cnt  <= r_cnt + 2'd1;
                    end
                end
                S_GET_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata <= {i_rx_data, r_wdata[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                    end
                end
                S_ISSUE: begin
                    r_tmo <= 16'd0;
                    if (w_cmd_fire && r_is_wr) begin
                        r_tx_data <= ST_ACK;
                    end
                end
                S_WAIT_RSP: begin
                    r_tmo <= r_tmo + 16'd1;
                    if (i_dBus_rsp_ready) begin
                        if (i_dBus_rsp_error) begin
                            r_tx_data <= ST_NAK;
                        end else begin
                            r_tx_data   <= ST_ACK;
                            r_rd_data   <= i_dBus_rsp_data;
                            r_send_data <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_tx_data <= ST_NAK;
                    end
                end
                S_SEND_STAT: begin
                    if (w_tx_fire && r_send_data) begin
                        r_tx_data <= r_rd_data[7:0];
                        r_rd_data <= {8'h00, r_rd_data[31:8]};
                        r_cnt     <= 2'd0;
                    end
                end
                S_SEND_DATA: begin
                    if (w_tx_fire) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt != 2'd3) begin
                            r_tx_data <= r_rd_data[7:0];
                            r_rd_data <= {8'h00, r_rd_data[31:8]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rx_ready                 = r_rx_ready;
    assign o_tx_valid                 = r_tx_valid;
    assign o_tx_data                  = r_tx_data;
    assign o_dBus_cmd_valid           = r_cmd_valid;
    assign o_dBus_cmd_payload_wr      = r_is_wr;
    assign o_dBus_cmd_payload_address = {r_addr[31:2], 2'b00};
    assign o_dBus_cmd_payload_data    = r_wdata;
    assign o_dBus_cmd_payload_size    = 2'd2;
    assign o_busy                     = (r_state != S_IDLE);

endmodule

// File: tb/tb_dbus_cmd_bridge.sv
// tb/tb_dbus_cmd_bridge.sv - randomized self-checking bench for dbus_cmd_bridge
// Responder and packet-level reference model live here; DUT runs with a short read timeout.
module tb_dbus_cmd_bridge;

    localparam int         TMO  = 4;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_size;
    logic        rsp_ready;
    logic        rsp_error;
    logic [31:0] rsp_data;
    logic        busy;

    dbus_cmd_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk                      (clk),
        .i_reset                    (reset),
        .i_rx_valid                 (rx_valid),
        .o_rx_ready                 (rx_ready),
        .i_rx_data                  (rx_data),
        .o_tx_valid                 (tx_valid),
        .i_tx_ready                 (tx_ready),
        .o_tx_data                  (tx_data),
        .o_dBus_cmd_valid           (cmd_valid),
        .i_dBus_cmd_ready           (cmd_ready),
        .o_dBus_cmd_payload_wr      (cmd_wr),
        .o_dBus_cmd_payload_address (cmd_addr),
        .o_dBus_cmd_payload_data    (cmd_data),
        .o_dBus_cmd_payload_size    (cmd_size),
        .i_dBus_rsp_ready           (rsp_ready),
        .i_dBus_rsp_error           (rsp_error),
        .i_dBus_rsp_data            (rsp_data),
        .o_busy                     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          cfg_lat   = 0;
    bit          cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;
    int          cfg_dly   = 0;
    bit          cfg_thr   = 1'b0;

    logic [7:0]  got_tx[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic        got_wr[$];
    logic [1:0]  got_size[$];
    int          cv_len_q[$];
    int          cv_len       = 0;
    int          unstable     = 0;
    int          tx_unstable  = 0;
    int          stall        = 0;
    int          first_tx_cyc = -1;
    int          hs_cyc       = -1;
    int          last_rx_cyc  = -1;
    int          rsp_due      = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Responder: cmd_ready after cfg_dly stalled cycles, read data cfg_lat cycles after the handshake.
    initial begin
        cmd_ready = 1'b1;
        rsp_ready = 1'b0;
        rsp_error = 1'b0;
        rsp_data  = 32'h0;
        tx_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready = (cfg_dly == 0) || (cv_len >= cfg_dly);
            rsp_ready = (cyc == rsp_due);
            rsp_error = rsp_ready && cfg_err;
            rsp_data  = rsp_ready ? cfg_rdata : $urandom();
            tx_ready  = cfg_thr ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        logic        prev_v, prev_hs, prev_wr, prev_tv, prev_tf;
        logic [31:0] prev_a, prev_d;
        logic [7:0]  prev_td;
        prev_v = 1'b0; prev_hs = 1'b0; prev_wr = 1'b0; prev_a = '0; prev_d = '0;
        prev_tv = 1'b0; prev_tf = 1'b0; prev_td = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v  = 1'b0;
                prev_tv = 1'b0;
                cv_len  = 0;
            end else begin
                if (tx_valid && first_tx_cyc < 0) first_tx_cyc = cyc;
                if (tx_valid && tx_ready) got_tx.push_back(tx_data);
                if (prev_tv && !prev_tf && (!tx_valid || tx_data !== prev_td)) tx_unstable++;
                if (rx_valid && !rx_ready) stall++;
                if (prev_v && !prev_hs &&
                    (!cmd_valid || cmd_wr !== prev_wr || cmd_addr !== prev_a || cmd_data !== prev_d))
                    unstable++;
                if (cmd_valid) begin
                    cv_len++;
                    if (cmd_ready) begin
                        got_wr.push_back(cmd_wr);
                        got_addr.push_back(cmd_addr);
                        got_data.push_back(cmd_data);
                        got_size.push_back(cmd_size);
                        cv_len_q.push_back(cv_len);
                        cv_len = 0;
                        hs_cyc = cyc;
                        if (!cmd_wr && cfg_lat > 0) rsp_due = cyc + cfg_lat;
                    end
                end
                prev_v  = cmd_valid;
                prev_hs = cmd_valid && cmd_ready;
                prev_wr = cmd_wr;
                prev_a  = cmd_addr;
                prev_d  = cmd_data;
                prev_tv = tx_valid;
                prev_tf = tx_valid && tx_ready;
                prev_td = tx_data;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit thr);
        int guard;
        bit acc;
        if (thr) begin
            while ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        acc      = 1'b0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = rx_ready;
            if (acc) last_rx_cyc = cyc;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("rx_accept", 64'(acc), 64'd1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_cmd_wr"}, 64'(cmd_wr), 64'd0);
        check({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
        check({tag, "_cmd_data"}, 64'(cmd_data), 64'd0);
        check({tag, "_cmd_size"}, 64'(cmd_size), 64'd2);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Reference: a packet yields at most one bus command and a reply decided by whether
    // a clean response lands within TMO cycles after the handshake.
    task automatic run_pkt(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int lat, input bit err, input logic [31:0] rdata,
                           input int dly, input bit thr);
        logic [7:0] pkt[$];
        logic [7:0] exp_tx[$];
        bit         has_cmd, is_wr, in_window;
        int         guard;
        cfg_lat = lat; cfg_err = err; cfg_rdata = rdata; cfg_dly = dly; cfg_thr = thr;
        got_tx.delete(); got_addr.delete(); got_data.delete(); got_wr.delete();
        got_size.delete(); cv_len_q.delete();
        unstable = 0; tx_unstable = 0; stall = 0;
        first_tx_cyc = -1; hs_cyc = -1;

        has_cmd   = (op == OP_W) || (op == OP_R);
        is_wr     = (op == OP_W);
        in_window = (lat >= 1) && (lat <= TMO);
        pkt.push_back(op);
        if (has_cmd) for (int i = 0; i < 4; i++) pkt.push_back(addr[8*i +: 8]);
        if (is_wr) for (int i = 0; i < 4; i++) pkt.push_back(wdata[8*i +: 8]);
        if (!has_cmd) exp_tx.push_back(NAK);
        else if (is_wr) exp_tx.push_back(ACK);
        else if (in_window && !err) begin
            exp_tx.push_back(ACK);
            for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
        end else exp_tx.push_back(NAK);

        foreach (pkt[i]) send_byte(pkt[i], thr);

        guard = 0;
        while (got_tx.size() < exp_tx.size() && guard < 300) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("tx_arrived", 64'(got_tx.size() >= exp_tx.size()), 64'd1);
        @(negedge clk);
        #1;
        check("busy_after_last", 64'(busy), 64'd0);
        repeat (TMO + 6) @(negedge clk);
        #1;

        check("tx_count", 64'(got_tx.size()), 64'(exp_tx.size()));
        foreach (exp_tx[i])
            check($sformatf("tx_byte%0d", i), 64'((i < got_tx.size()) ? got_tx[i] : 8'hxx), 64'(exp_tx[i]));
        check("tx_stable", 64'(tx_unstable), 64'd0);
        check("rx_no_stall", 64'(stall), 64'd0);
        check("cmd_count", 64'(got_wr.size()), 64'(has_cmd));
        check("cmd_stable", 64'(unstable), 64'd0);
        if (has_cmd && got_wr.size() > 0) begin
            check("cmd_wr", 64'(got_wr[0]), 64'(is_wr));
            check("cmd_addr", 64'(got_addr[0]), 64'(addr & 32'hFFFF_FFFC));
            check("cmd_size", 64'(got_size[0]), 64'd2);
            check("cmd_cycles", 64'(cv_len_q[0]), 64'(dly + 1));
            if (is_wr) check("cmd_data", 64'(got_data[0]), 64'(wdata));
            if (is_wr || in_window)
                check("turnaround", 64'(first_tx_cyc - last_rx_cyc),
                      64'(2 + dly + (is_wr ? 0 : lat)));
            else
                check("timeout_delay", 64'(first_tx_cyc - hs_cyc), 64'(TMO + 1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [7:0] op;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rx_ready_after_reset", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;

        run_pkt(OP_W, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 0, 1'b0);
        run_pkt(OP_R, 32'h0000_0004, 32'h0, 1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
        run_pkt(OP_R, 32'h8000_0003, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 5, 1'b0);
        run_pkt(OP_R, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0);
        run_pkt(OP_R, 32'h0000_0014, 32'h0, TMO + 1, 1'b0, 32'h1111_2222, 0, 1'b0);
        run_pkt(OP_R, 32'h0000_0018, 32'h0, TMO, 1'b0, 32'h3344_5566, 0, 1'b0);
        run_pkt(OP_R, 32'h0000_001C, 32'h0, 1, 1'b1, 32'h7777_8888, 0, 1'b0);
        run_pkt(8'h41, 32'h0, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0);
        run_pkt(OP_R, 32'h1234_5678, 32'h0, 2, 1'b0, 32'hA1B2_C3D4, 0, 1'b1);

        cfg_dly = 0;
        cfg_thr = 1'b0;
        send_byte(OP_W, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid");
        @(negedge clk);
        check("rx_ready_after_mid_reset", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        run_pkt(OP_W, 32'h4000_0100, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OP_W;
                4, 5, 6, 7: op = OP_R;
                default: begin
                    op = 8'($urandom());
                    if (op == OP_W || op == OP_R) op = 8'h41;
                end
            endcase
            run_pkt(op, $urandom(), $urandom(), int'($urandom_range(0, TMO + 2)),
                    ($urandom_range(0, 7) == 0), $urandom(), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
